// File: rtl/row_vector_pkg.sv
// Shared types and constants for the row-by-vector issue path: FSM encoding,
// datapath widths, watchdog limit and the chunk-count clamp.
package row_vector_pkg;

  localparam int unsigned CHUNK_W = 192;
  localparam int unsigned CPLX_W  = 64;

  localparam int unsigned WD_W     = 6;
  localparam logic [5:0]  WD_LIMIT = 6'd32;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StIssue,
    StWait
  } issuer_state_e;

  // A zero chunk count still issues one chunk; anything above the maximum saturates.
  function automatic logic [3:0] clamp_multiples(input logic [3:0] raw, input logic [3:0] max_n);
    if (raw == 4'd0) begin
      return 4'd1;
    end else if (raw > max_n) begin
      return max_n;
    end else begin
      return raw;
    end
  endfunction

endpackage

// File: rtl/row_result_fifo.sv
// Small synchronous FIFO holding completed row sums; supports push and pop in
// the same cycle, including when full.
module row_result_fifo #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_q, rd_q;
  logic [CntW-1:0]  cnt_q;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  always_comb begin
    empty   = (cnt_q == '0);
    full    = (cnt_q == CntW'(Depth));
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    head    = mem[rd_q];
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_q] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        wr_q <= next_ptr(wr_q);
      end
      if (do_pop) begin
        rd_q <= next_ptr(rd_q);
      end
      if (do_push && !do_pop) begin
        cnt_q <= cnt_q + CntW'(1);
      end else if (do_pop && !do_push) begin
        cnt_q <= cnt_q - CntW'(1);
      end
    end
  end

endmodule

// File: rtl/row_vector_issuer.sv
// Streams one row of 192-bit chunks (plus matching vector chunks) into the
// row-by-vector unit and queues its row sums. Define ROW_ISSUER_TIMEOUT_EN for the WAIT watchdog.
module row_vector_issuer
  import row_vector_pkg::*;
#(
  parameter int unsigned MAX_MULTIPLES = 8,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               row_start,
  input  logic [3:0]         row_multiples,
  output logic [2:0]         chunk_addr,
  input  logic [CHUNK_W-1:0] row_chunk_data,
  input  logic [CHUNK_W-1:0] vec_chunk_data,
  output logic [CHUNK_W-1:0] a,
  output logic [CHUNK_W-1:0] p,
  output logic               start_row_by_vector,
  output logic [3:0]         number_of_multiples,
  input  logic               decoder_read_now,
  input  logic [CPLX_W-1:0]  result,
  output logic [CPLX_W-1:0]  row_result,
  output logic               row_result_valid,
  input  logic               row_result_ready,
  output logic               busy,
  output logic               overflow_err,
  output logic               timeout_err
);

  localparam logic [3:0] MaxMul = 4'(MAX_MULTIPLES);

  issuer_state_e      state_q, state_d;
  logic [2:0]         k_q, k_d;
  logic [3:0]         n_q, n_d;
  logic [CHUNK_W-1:0] a_q, p_q;
  logic               start_q;
  logic               overflow_q;
  logic               fifo_push, fifo_empty, fifo_full;
  logic               timeout_hit;

`ifdef ROW_ISSUER_TIMEOUT_EN
  logic [WD_W-1:0] wd_q;
  logic            timeout_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= (state_q == StWait) ? wd_q + WD_W'(1) : '0;
      timeout_q <= timeout_q | timeout_hit;
    end
  end

  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    n_d         = n_q;
    fifo_push   = 1'b0;
    timeout_hit = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Credit check: only start a row whose result is guaranteed a FIFO slot.
        if (row_start && !fifo_full) begin
          n_d     = clamp_multiples(row_multiples, MaxMul);
          k_d     = 3'd0;
          state_d = StFetch;
        end
      end
      StFetch: state_d = StIssue;
      StIssue: begin
        if (({1'b0, k_q} + 4'd1) < n_q) begin
          k_d     = k_q + 3'd1;
          state_d = StFetch;
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (decoder_read_now) begin
          fifo_push = 1'b1;
          state_d   = StIdle;
        end
`ifdef ROW_ISSUER_TIMEOUT_EN
        else if (wd_q == WD_LIMIT - 6'd1) begin
          timeout_hit = 1'b1;
          state_d     = StIdle;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      k_q        <= '0;
      n_q        <= '0;
      a_q        <= '0;
      p_q        <= '0;
      start_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      n_q        <= n_d;
      // Read data for chunk k arrives during ISSUE; a/p and the pulse appear together next cycle.
      start_q    <= (state_q == StIssue);
      overflow_q <= overflow_q | (decoder_read_now && (state_q != StWait));
      if (state_q == StIssue) begin
        a_q <= row_chunk_data;
        p_q <= vec_chunk_data;
      end
    end
  end

  row_result_fifo #(
    .Width(CPLX_W),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .push_data(result),
    .pop      (row_result_ready),
    .head     (row_result),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  assign chunk_addr          = k_q;
  assign a                   = a_q;
  assign p                   = p_q;
  assign start_row_by_vector = start_q;
  assign number_of_multiples = n_q;
  assign row_result_valid    = !fifo_empty;
  assign busy                = (state_q != StIdle);
  assign overflow_err        = overflow_q;

endmodule

// File: doc/row_vector_issuer.md
ROW_VECTOR_ISSUER -- requirements
Module: row_vector_issuer

Interface
REQ-001 SHALL have parameter MAX_MULTIPLES, default 8, the maximum number of 192-bit chunks per row.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, the number of row-result entries.
REQ-003 SHALL have the following ports: clk input 1, the single clock; reset input 1, asynchronous, active-low.
REQ-004 SHALL have row_start input 1, a request to issue one row.
REQ-005 SHALL have row_multiples input 4, the chunk count for the row, legal 1..MAX_MULTIPLES.
REQ-006 SHALL have chunk_addr output 3, the chunk index presented to the row/vector memories.
REQ-007 SHALL have row_chunk_data input 192 and vec_chunk_data input 192, memory read data with 1-cycle latency.
REQ-008 SHALL have a output 192 and p output 192, the three complex entries per operand sent to the row-by-vector unit.
REQ-009 SHALL have start_row_by_vector output 1 and number_of_multiples output 4, both driving the row-by-vector unit.
REQ-010 SHALL have decoder_read_now input 1 and result input 64, the completed row sum returned by the row-by-vector unit.
REQ-011 SHALL have row_result output 64, row_result_valid output 1 and row_result_ready input 1, a downstream valid/ready result port.
REQ-012 SHALL have busy output 1, overflow_err output 1 (sticky) and timeout_err output 1 (sticky).

Function
REQ-013 SHALL implement the FSM states IDLE, FETCH, ISSUE and WAIT.
REQ-014 SHALL accept row_start in IDLE only when credits > 0, where credits = FIFO_DEPTH - occupancy; when accepted it SHALL latch row_multiples and go to FETCH with chunk index 0.
REQ-015 SHALL ignore row_start outside IDLE and when credits = 0, with no side effects.
REQ-016 SHALL clamp a latched row_multiples of 0 to 1 and a value above MAX_MULTIPLES to MAX_MULTIPLES.
REQ-017 SHALL, in FETCH, drive chunk_addr = k and then go to ISSUE in the next cycle.
REQ-018 SHALL, in ISSUE, register row_chunk_data into a and vec_chunk_data into p, pulse start_row_by_vector for exactly one cycle, and keep a/p valid during that pulse.
REQ-019 SHALL make a and p hold their values until the next chunk is issued.
REQ-020 SHALL issue one chunk every 2 cycles, so a row of n chunks produces n start pulses spaced 2 cycles apart.
REQ-021 SHALL, in ISSUE, go to FETCH with k+1 if k+1 < n, otherwise to WAIT.
REQ-022 SHALL hold number_of_multiples equal to the latched n from acceptance until WAIT exits.
REQ-023 SHALL, in WAIT, on decoder_read_now, push result into the FIFO and go to IDLE.
REQ-024 SHALL treat decoder_read_now in any state other than WAIT as a protocol error: overflow_err is set and result is discarded.
REQ-025 SHALL make row_result_valid = FIFO not empty and row_result = FIFO head, with the head popped when valid and ready are both high.
REQ-026 SHALL allow a push and a pop in the same cycle, leaving occupancy unchanged.
REQ-027 SHALL drive busy high in every state other than IDLE.

Reset
REQ-028 SHALL, while reset = 0, force the state to IDLE and clear the FIFO pointers and occupancy.
REQ-029 SHALL, while reset = 0, clear a, p, chunk_addr, number_of_multiples, start_row_by_vector, row_result_valid, busy, overflow_err and timeout_err to 0.
REQ-030 SHALL abandon any in-flight row when reset is asserted mid-row, and a late decoder_read_now after release SHALL set overflow_err.

Configuration
REQ-031 SHALL, with ROW_ISSUER_TIMEOUT_EN defined, run a 6-bit watchdog in WAIT; if 32 cycles pass without decoder_read_now, it sets timeout_err, pushes nothing and returns to IDLE.
REQ-032 SHALL, without ROW_ISSUER_TIMEOUT_EN, wait in WAIT indefinitely and tie timeout_err to 0.

Structure
REQ-033 SHALL take the state encoding, CHUNK_W = 192, CPLX_W = 64 and the watchdog limit from shared package row_vector_pkg.
REQ-034 SHALL implement the result FIFO as sub-module row_result_fifo, parameterised by width and depth.

Verification
REQ-035 SHALL cover a single chunk: row_multiples = 1 and row_start -> exactly one start pulse with number_of_multiples = 1; decoder_read_now with result = 0x3F800000_40000000 -> row_result_valid with that value.
REQ-036 SHALL cover a three-chunk row: row_multiples = 3 -> chunk_addr steps 0, 1, 2, three start pulses 2 cycles apart, a/p matching the memory words, busy held until decoder_read_now.
REQ-037 SHALL cover backpressure: row_result_ready = 0 and four rows completed -> a fifth row_start is ignored (busy stays 0); one pop -> the next row_start is accepted.
REQ-038 SHALL cover spurious completion: decoder_read_now in IDLE -> overflow_err = 1 and the FIFO is unchanged.
REQ-039 SHALL cover reset during ISSUE of chunk 1 of 3 -> all outputs 0 immediately, state IDLE after release.
REQ-040 SHALL cover the timeout build: no decoder_read_now for 32 cycles -> timeout_err = 1 and IDLE; in the non-timeout build, busy stays 1.
